// File: rtl/logic_mux2_seq_pkg.sv
// rtl/logic_mux2_seq_pkg.sv - shared state type and default parameters for logic_mux2_sequencer
//
// Purpose: holds the sequencer state encoding and the default parameter
// values so the sequencer and anything that instantiates it agree on them.
// Ports: none (package).

package logic_mux2_seq_pkg;

  // Sequencer states, 3-bit encoding.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } seq_state_t;

  // Default parameter values.
  localparam int DEF_WIDTH      = 3;
  localparam int DEF_CNT_W      = 8;
  localparam int DEF_SIG_W      = 16;
  localparam int DEF_SETTLE_CYC = 1;

endpackage

// File: rtl/logic_mux2_sequencer.sv
// rtl/logic_mux2_sequencer.sv - run sequencer driving rotating a/b/c vectors into the logic mux and sampling y
//
// Purpose: on an accepted start, drives num_iter rotating vectors
// (a=iter+1, b=iter, c=iter+2, all modulo 2^WIDTH) into the mux. After each
// vector it waits SETTLE_CYC cycles, then samples y_in into a ones count and
// a shift signature. A single-cycle done pulse ends the run.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset (aborts any run, no done)
//   start     in   run request, only looked at in IDLE
//   num_iter  in   vectors per run, latched when start is accepted
//   y_in      in   mux output y
//   a_out     out  mux input a
//   b_out     out  mux input b
//   c_out     out  mux input c
//   busy      out  high in DRIVE/SETTLE/SAMPLE
//   done      out  high for the single DONE cycle
//   ones_cnt  out  samples with y_in=1 in the last run
//   sig       out  shift signature of the last run (newest sample in bit 0)

module logic_mux2_sequencer
  import logic_mux2_seq_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int SIG_W      = DEF_SIG_W,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_iter,
  input  logic             y_in,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic [WIDTH-1:0] c_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] ones_cnt,
  output logic [SIG_W-1:0] sig
);

  seq_state_t       r_state;
  seq_state_t       w_next;

  logic [CNT_W-1:0] r_iter;
  logic [CNT_W-1:0] r_n_lat;
  logic [3:0]       r_settle_cnt;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_c;
  logic [CNT_W-1:0] r_ones;
  logic [SIG_W-1:0] r_sig;

  logic             w_last;
  logic             w_settle_done;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_c;

  // The vector values wrap naturally because the sums are WIDTH bits wide.
  assign w_b = WIDTH'(r_iter);
  assign w_a = w_b + WIDTH'(1);
  assign w_c = w_b + WIDTH'(2);

  assign w_last = (r_iter == r_n_lat - CNT_W'(1));

  // SETTLE is only entered when SETTLE_CYC >= 1, so the wrapped compare
  // value for SETTLE_CYC=0 is never used.
  assign w_settle_done = (r_settle_cnt == 4'(SETTLE_CYC - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next = (num_iter != '0) ? DRIVE : DONE;
        end
      end
      DRIVE: begin
        w_next = (SETTLE_CYC == 0) ? SAMPLE : SETTLE;
      end
      SETTLE: begin
        if (w_settle_done) begin
          w_next = SAMPLE;
        end
      end
      SAMPLE: begin
        w_next = w_last ? DONE : DRIVE;
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_iter       <= '0;
      r_n_lat      <= '0;
      r_settle_cnt <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_c          <= '0;
      r_ones       <= '0;
      r_sig        <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            // A zero-length run still clears the results so the DONE
            // pulse reports an empty run, but no vector is driven.
            r_ones <= '0;
            r_sig  <= '0;
            if (num_iter != '0) begin
              r_n_lat <= num_iter;
              r_iter  <= '0;
            end
          end
        end
        DRIVE: begin
          r_a          <= w_a;
          r_b          <= w_b;
          r_c          <= w_c;
          r_settle_cnt <= '0;
        end
        SETTLE: begin
          r_settle_cnt <= r_settle_cnt + 4'd1;
        end
        SAMPLE: begin
          r_sig <= {r_sig[SIG_W-2:0], y_in};
          if (y_in && (r_ones != '1)) begin
            r_ones <= r_ones + CNT_W'(1);
          end
          if (!w_last) begin
            r_iter <= r_iter + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign a_out    = r_a;
  assign b_out    = r_b;
  assign c_out    = r_c;
  assign ones_cnt = r_ones;
  assign sig      = r_sig;
  assign busy     = (r_state == DRIVE) || (r_state == SETTLE) || (r_state == SAMPLE);
  assign done     = (r_state == DONE);

endmodule

// File: tb/tb_logic_mux2_sequencer.sv
// tb/tb_logic_mux2_sequencer.sv - self-checking bench for logic_mux2_sequencer

module tb_logic_mux2_sequencer;

  localparam int W  = 3;
  localparam int CW = 8;
  localparam int SW = 16;
  localparam int S  = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] num_iter;
  logic          y_in;
  logic [W-1:0]  a_out;
  logic [W-1:0]  b_out;
  logic [W-1:0]  c_out;
  logic          busy;
  logic          done;
  logic [CW-1:0] ones_cnt;
  logic [SW-1:0] sig;

  int checks   = 0;
  int failures = 0;

  // Reference model: last vector driven, results of last run.
  int ea = 0;
  int eb = 0;
  int ec = 0;
  int last_ones = 0;
  int last_sig  = 0;

  logic_mux2_sequencer #(
    .WIDTH      (W),
    .CNT_W      (CW),
    .SIG_W      (SW),
    .SETTLE_CYC (S)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .num_iter (num_iter),
    .y_in     (y_in),
    .a_out    (a_out),
    .b_out    (b_out),
    .c_out    (c_out),
    .busy     (busy),
    .done     (done),
    .ones_cnt (ones_cnt),
    .sig      (sig)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One run of n vectors. ymode: 0 random y, 1 y tied 1, 2 y = a[0].
  // Expected timing follows the latency rule: cycle k after the accepting
  // edge sits at position (k-1) mod (S+2) of iteration (k-1)/(S+2), and the
  // DONE cycle is k = n*(S+2)+1.
  task automatic run(input int n, input int ymode, input bit repulse);
    int total;
    int p;
    int i;
    int y;
    int eones;
    int esig;
    int m;
    m     = 1 << W;
    eones = 0;
    esig  = 0;
    num_iter = CW'(n);
    start    = 1'b1;
    y_in     = (ymode == 1) ? 1'b1 : 1'b0;
    step();
    start = 1'b0;
    total = n * (S + 2) + 1;
    for (int k = 1; k <= total; k++) begin
      if (repulse) begin
        start    = 1'($urandom);
        num_iter = CW'($urandom_range(1, 255));
      end
      y_in = (ymode == 1) ? 1'b1 : 1'($urandom);
      if (k == total) begin
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_in_done", 32'(busy), 32'd0);
        chk("ones_cnt", 32'(ones_cnt), 32'(eones));
        chk("sig", 32'(sig), 32'(esig));
        chk("a_hold", 32'(a_out), 32'(ea));
        chk("b_hold", 32'(b_out), 32'(eb));
        chk("c_hold", 32'(c_out), 32'(ec));
      end else begin
        p = (k - 1) % (S + 2);
        i = (k - 1) / (S + 2);
        chk("busy_run", 32'(busy), 32'd1);
        chk("done_run", 32'(done), 32'd0);
        if (p >= 1) begin
          ea = (i + 1) % m;
          eb = i % m;
          ec = (i + 2) % m;
          chk("a_vec", 32'(a_out), 32'(ea));
          chk("b_vec", 32'(b_out), 32'(eb));
          chk("c_vec", 32'(c_out), 32'(ec));
        end
        if (p == S + 1) begin
          if (ymode == 1)      y = 1;
          else if (ymode == 2) y = ea & 1;
          else                 y = int'($urandom_range(0, 1));
          y_in  = 1'(y);
          esig  = ((esig << 1) | y) & ((1 << SW) - 1);
          eones = (eones + y > (1 << CW) - 1) ? (1 << CW) - 1 : eones + y;
        end
      end
      step();
    end
    start = 1'b0;
    chk("busy_after", 32'(busy), 32'd0);
    chk("done_once", 32'(done), 32'd0);
    last_ones = eones;
    last_sig  = esig;
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    num_iter = '0;
    y_in     = 1'b0;
    step();
    step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_a", 32'(a_out), 32'd0);
    chk("rst_b", 32'(b_out), 32'd0);
    chk("rst_c", 32'(c_out), 32'd0);
    chk("rst_ones", 32'(ones_cnt), 32'd0);
    chk("rst_sig", 32'(sig), 32'd0);
    rst = 1'b0;
    step();

    run(10, 1, 1'b0);
    chk("tp_n10_ones", 32'(ones_cnt), 32'd10);
    chk("tp_n10_sig", 32'(sig), 32'h03FF);

    run(20, 1, 1'b0);
    chk("tp_n20_ones", 32'(ones_cnt), 32'd20);
    chk("tp_n20_sig", 32'(sig), 32'hFFFF);

    run(4, 2, 1'b0);
    chk("tp_a0_ones", 32'(ones_cnt), 32'd2);
    chk("tp_a0_sig", 32'(sig), 32'h000A);

    run(0, 0, 1'b0);
    chk("tp_n0_ones", 32'(ones_cnt), 32'd0);
    chk("tp_n0_sig", 32'(sig), 32'd0);

    run(5, 0, 1'b1);

    // Reset during the third SETTLE cycle of a 5-vector run.
    num_iter = CW'(5);
    start    = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k < 8; k++) step();
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_a", 32'(a_out), 32'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_a", 32'(a_out), 32'd0);
    chk("abort_b", 32'(b_out), 32'd0);
    chk("abort_c", 32'(c_out), 32'd0);
    chk("abort_ones", 32'(ones_cnt), 32'd0);
    chk("abort_sig", 32'(sig), 32'd0);
    ea = 0;
    eb = 0;
    ec = 0;
    for (int k = 0; k < 12; k++) begin
      chk("abort_no_done", 32'(done), 32'd0);
      step();
    end
    run(2, 0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      run(int'($urandom_range(0, 40)), int'($urandom_range(0, 2)), 1'($urandom));
    end

    run(255, 1, 1'b0);
    chk("n255_ones", 32'(ones_cnt), 32'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
